// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared definitions for the UART FIFO sequencing controller: TX FSM state
// encoding and the default RX character-timeout length.
package uart_fifo_ctrl_pkg;

  // TX sequencer states; encodings are fixed so the register block can decode them.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_FETCH = 2'd1,
    TX_SEND  = 2'd2
  } tx_state_e;

  // Default RX character-timeout length in clk_i cycles.
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// Valid/ready character stream between the FIFO controller and the UART
// serializer. The controller is the master; the serializer is the slave.
interface uart_fifo_ctrl_if #(
  parameter int DATA_SIZE = 8
);
  import uart_fifo_ctrl_pkg::*;

  logic                 valid;
  logic [DATA_SIZE-1:0] data;
  logic                 ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/uart_tx_sequencer.sv
// TX sequencer: pulls one character from the TX FIFO, holds it on the
// serializer handshake until accepted, then returns to IDLE. Every output
// is a flop so nothing combinational reaches the FIFO or the serializer.
module uart_tx_sequencer
  import uart_fifo_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 rst_i,
  input  logic                 tx_en_i,
  input  logic                 tx_fifo_load_i,
  input  logic [DATA_SIZE-1:0] tx_fifo_data_i,
  output logic                 tx_fifo_pull_o,
  output logic                 tx_valid_o,
  output logic [DATA_SIZE-1:0] tx_data_o,
  input  logic                 tx_ready_i,
  output logic                 tx_busy_o
);

  tx_state_e            state_q;
  logic                 pull_q;
  logic                 valid_q;
  logic [DATA_SIZE-1:0] data_q;
  logic                 busy_q;

  // TX FSM with registered pull, valid, data and busy outputs.
  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= TX_IDLE;
      pull_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else if (rst_i) begin
      state_q <= TX_IDLE;
      pull_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      pull_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          // Only start when the FIFO head is valid, so a pull never hits an empty FIFO.
          if (tx_en_i && tx_fifo_load_i) begin
            state_q <= TX_FETCH;
            pull_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        TX_FETCH: begin
          // The head is still presented during the pull cycle; capture it now.
          data_q  <= tx_fifo_data_i;
          valid_q <= 1'b1;
          state_q <= TX_SEND;
        end
        TX_SEND: begin
          // tx_en_i is ignored here: a character once fetched is always delivered.
          if (tx_ready_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= TX_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

  assign tx_fifo_pull_o = pull_q;
  assign tx_valid_o     = valid_q;
  assign tx_data_o      = data_q;
  assign tx_busy_o      = busy_q;

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART FIFO sequencing controller: TX FIFO -> serializer via the TX
// sequencer, deserializer -> RX FIFO with overrun protection, plus the
// RX-trigger, TX-empty and (optional) RX-timeout interrupt levels.
// Optional feature macro: UART_FIFO_CTRL_RX_TIMEOUT_EN (RX character timeout).
module uart_fifo_ctrl
  import uart_fifo_ctrl_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int INDEX_LENGTH = 4,
  parameter int FIFO_SIZE    = 16
`ifdef UART_FIFO_CTRL_RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    rst_i,
  input  logic                    tx_en_i,
  input  logic                    tx_fifo_load_i,
  input  logic [DATA_SIZE-1:0]    tx_fifo_data_i,
  output logic                    tx_fifo_pull_o,
  uart_fifo_ctrl_if.master        tx_ser,
  input  logic                    rx_en_i,
  input  logic                    rx_valid_i,
  input  logic [DATA_SIZE-1:0]    rx_data_i,
  output logic                    rx_fifo_push_o,
  output logic [DATA_SIZE-1:0]    rx_fifo_data_o,
  input  logic [INDEX_LENGTH:0]   rx_fifo_space_i,
  input  logic                    rx_fifo_load_i,
  input  logic [INDEX_LENGTH:0]   rx_trig_i,
  input  logic                    overrun_clr_i,
  output logic                    overrun_o,
  output logic                    irq_rx_o,
  output logic                    irq_tx_empty_o,
  output logic                    irq_rx_timeout_o,
  output logic                    tx_busy_o
);

  localparam logic [INDEX_LENGTH:0] FIFO_SIZE_W = (INDEX_LENGTH+1)'(FIFO_SIZE);

  logic                  tx_busy;
  logic                  push_q,         push_d;
  logic [DATA_SIZE-1:0]  rx_data_q,      rx_data_d;
  logic                  overrun_q,      overrun_d;
  logic                  irq_rx_q,       irq_rx_d;
  logic                  irq_tx_empty_q, irq_tx_empty_d;
  logic [INDEX_LENGTH:0] eff_space;
  logic [INDEX_LENGTH:0] fill;

  uart_tx_sequencer #(
    .DATA_SIZE (DATA_SIZE)
  ) u_tx_seq (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .rst_i          (rst_i),
    .tx_en_i        (tx_en_i),
    .tx_fifo_load_i (tx_fifo_load_i),
    .tx_fifo_data_i (tx_fifo_data_i),
    .tx_fifo_pull_o (tx_fifo_pull_o),
    .tx_valid_o     (tx_ser.valid),
    .tx_data_o      (tx_ser.data),
    .tx_ready_i     (tx_ser.ready),
    .tx_busy_o      (tx_busy)
  );

  // Next-state for RX push, sticky overrun and the interrupt levels.
  // NOTE: every variable gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    push_d         = 1'b0;
    rx_data_d      = rx_data_q;
    overrun_d      = overrun_q;
    // The space input lags our own push by a cycle, so discount it here.
    eff_space      = rx_fifo_space_i - {{INDEX_LENGTH{1'b0}}, push_q};
    fill           = FIFO_SIZE_W - rx_fifo_space_i;

    if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end
    // Placed after the clear so a simultaneous set wins.
    if (rx_valid_i && rx_en_i) begin
      if (eff_space != '0) begin
        push_d    = 1'b1;
        rx_data_d = rx_data_i;
      end else begin
        overrun_d = 1'b1;
      end
    end

    irq_rx_d       = (rx_trig_i != '0) && rx_fifo_load_i && (fill >= rx_trig_i);
    irq_tx_empty_d = !tx_busy && !tx_fifo_load_i;
  end

  // RX and interrupt state registers; soft reset behaves like the async one.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      push_q         <= 1'b0;
      rx_data_q      <= '0;
      overrun_q      <= 1'b0;
      irq_rx_q       <= 1'b0;
      irq_tx_empty_q <= 1'b1;
    end else if (rst_i) begin
      push_q         <= 1'b0;
      rx_data_q      <= '0;
      overrun_q      <= 1'b0;
      irq_rx_q       <= 1'b0;
      irq_tx_empty_q <= 1'b1;
    end else begin
      push_q         <= push_d;
      rx_data_q      <= rx_data_d;
      overrun_q      <= overrun_d;
      irq_rx_q       <= irq_rx_d;
      irq_tx_empty_q <= irq_tx_empty_d;
    end
  end

`ifdef UART_FIFO_CTRL_RX_TIMEOUT_EN
  localparam int              TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0]       to_cnt_q;
  logic                  irq_to_q;
  logic [INDEX_LENGTH:0] space_prev_q;

  // Character timeout: count idle cycles with unread data below the trigger;
  // saturate at the limit and hold the interrupt until new activity.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      to_cnt_q     <= '0;
      irq_to_q     <= 1'b0;
      space_prev_q <= FIFO_SIZE_W;
    end else if (rst_i) begin
      to_cnt_q     <= '0;
      irq_to_q     <= 1'b0;
      space_prev_q <= FIFO_SIZE_W;
    end else begin
      space_prev_q <= rx_fifo_space_i;
      // A rise in free space means software pulled from the RX FIFO.
      if (rx_valid_i || (rx_fifo_space_i > space_prev_q)) begin
        to_cnt_q <= '0;
        irq_to_q <= 1'b0;
      end else begin
        if (rx_fifo_load_i && !irq_rx_q && (to_cnt_q != TO_MAX)) begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
        end
        if (to_cnt_q == TO_MAX) begin
          irq_to_q <= 1'b1;
        end
      end
    end
  end

  assign irq_rx_timeout_o = irq_to_q;
`else
  assign irq_rx_timeout_o = 1'b0;
`endif

  assign rx_fifo_push_o = push_q;
  assign rx_fifo_data_o = rx_data_q;
  assign overrun_o      = overrun_q;
  assign irq_rx_o       = irq_rx_q;
  assign irq_tx_empty_o = irq_tx_empty_q;
  assign tx_busy_o      = tx_busy;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: reset values, a table of interrupt-level
// vectors, and hand-written TX/RX sequences for the multi-cycle cases.
module tb_uart_fifo_ctrl;

`ifdef UART_FIFO_CTRL_RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic       rst = 1'b0;
  logic       tx_en = 1'b0;
  logic       tx_fifo_load;
  logic [7:0] tx_fifo_data;
  logic       tx_fifo_pull;
  logic       rx_en = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_fifo_push;
  logic [7:0] rx_fifo_data;
  logic [4:0] rx_fifo_space;
  logic       rx_fifo_load;
  logic [4:0] rx_trig = 5'd0;
  logic       overrun_clr = 1'b0;
  logic       overrun, irq_rx, irq_tx_empty, irq_rx_timeout, tx_busy;

  // Manual overrides for the FIFO status inputs, or small FIFO models.
  logic       tx_man_en = 1'b1;
  logic       tx_load_man = 1'b0;
  logic       rx_model_en = 1'b0;
  logic [4:0] rx_space_man = 5'd16;
  logic       rx_load_man = 1'b0;

  logic [7:0] tx_mem [4];
  int         tx_wr = 0;
  int         tx_rd = 0;
  int         rx_cnt = 0;
  int         rx_base = 0;

  int         pull_cnt = 0;
  int         xfer_cnt = 0;
  int         push_cnt = 0;
  logic [7:0] last_xfer = 8'h00;
  logic [7:0] last_push = 8'h00;

  int total = 0;
  int bad = 0;

  uart_fifo_ctrl_if #(.DATA_SIZE(8)) tx_ser ();

  assign tx_fifo_load  = tx_man_en ? tx_load_man : (tx_wr != tx_rd);
  assign tx_fifo_data  = tx_mem[tx_rd % 4];
  assign rx_fifo_space = rx_model_en ? 5'(16 - (rx_cnt - rx_base)) : rx_space_man;
  assign rx_fifo_load  = rx_model_en ? ((rx_cnt - rx_base) != 0) : rx_load_man;

  uart_fifo_ctrl #(
    .DATA_SIZE    (8),
    .INDEX_LENGTH (4),
    .FIFO_SIZE    (16)
`ifdef UART_FIFO_CTRL_RX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk_i            (clk),
    .arstn_i          (arstn),
    .rst_i            (rst),
    .tx_en_i          (tx_en),
    .tx_fifo_load_i   (tx_fifo_load),
    .tx_fifo_data_i   (tx_fifo_data),
    .tx_fifo_pull_o   (tx_fifo_pull),
    .tx_ser           (tx_ser),
    .rx_en_i          (rx_en),
    .rx_valid_i       (rx_valid),
    .rx_data_i        (rx_data),
    .rx_fifo_push_o   (rx_fifo_push),
    .rx_fifo_data_o   (rx_fifo_data),
    .rx_fifo_space_i  (rx_fifo_space),
    .rx_fifo_load_i   (rx_fifo_load),
    .rx_trig_i        (rx_trig),
    .overrun_clr_i    (overrun_clr),
    .overrun_o        (overrun),
    .irq_rx_o         (irq_rx),
    .irq_tx_empty_o   (irq_tx_empty),
    .irq_rx_timeout_o (irq_rx_timeout),
    .tx_busy_o        (tx_busy)
  );

  always #5 clk = ~clk;

  // FIFO models and transfer monitors, sampled at the active edge.
  always @(posedge clk) begin
    if (tx_fifo_pull) begin
      pull_cnt++;
      tx_rd <= tx_rd + 1;
    end
    if (tx_ser.valid && tx_ser.ready) begin
      xfer_cnt++;
      last_xfer = tx_ser.data;
    end
    if (rx_fifo_push) begin
      push_cnt++;
      last_push = rx_fifo_data;
      rx_cnt <= rx_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_push(input logic [7:0] b);
    tx_mem[tx_wr % 4] = b;
    tx_wr++;
  endtask

  typedef struct {
    logic [4:0] space;
    logic       load;
    logic [4:0] trig;
    logic       tx_load;
    logic       exp_irq_rx;
    logic       exp_tx_empty;
  } vec_t;

  vec_t vecs [9];
  int   p0, x0, q0;

  initial begin
    // fill = 16 - space; irq_rx = trig!=0 && load && fill>=trig; tx_empty = idle && !tx_load
    vecs[0] = '{5'd16, 1'b0, 5'd4,  1'b0, 1'b0, 1'b1};
    vecs[1] = '{5'd12, 1'b1, 5'd4,  1'b1, 1'b1, 1'b0};
    vecs[2] = '{5'd13, 1'b1, 5'd4,  1'b0, 1'b0, 1'b1};
    vecs[3] = '{5'd12, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0};
    vecs[4] = '{5'd0,  1'b1, 5'd16, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{5'd1,  1'b1, 5'd16, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{5'd15, 1'b1, 5'd1,  1'b0, 1'b1, 1'b1};
    vecs[7] = '{5'd12, 1'b0, 5'd4,  1'b0, 1'b0, 1'b1};
    vecs[8] = '{5'd0,  1'b1, 5'd1,  1'b1, 1'b1, 1'b0};

    tx_ser.ready = 1'b0;
    tick(3);
    arstn = 1'b1;
    tick(1);

    // Reset values.
    check("rst_pull",       32'(tx_fifo_pull),   32'd0);
    check("rst_valid",      32'(tx_ser.valid),   32'd0);
    check("rst_tx_data",    32'(tx_ser.data),    32'd0);
    check("rst_push",       32'(rx_fifo_push),   32'd0);
    check("rst_rx_data",    32'(rx_fifo_data),   32'd0);
    check("rst_overrun",    32'(overrun),        32'd0);
    check("rst_irq_rx",     32'(irq_rx),         32'd0);
    check("rst_tx_empty",   32'(irq_tx_empty),   32'd1);
    check("rst_timeout",    32'(irq_rx_timeout), 32'd0);
    check("rst_busy",       32'(tx_busy),        32'd0);

    // Interrupt-level vectors with the TX FSM held idle.
    for (int i = 0; i < 9; i++) begin
      rx_space_man = vecs[i].space;
      rx_load_man  = vecs[i].load;
      rx_trig      = vecs[i].trig;
      tx_load_man  = vecs[i].tx_load;
      tick(1);
      check($sformatf("vec%0d_irq_rx", i),   32'(irq_rx),       32'(vecs[i].exp_irq_rx));
      check($sformatf("vec%0d_tx_empty", i), 32'(irq_tx_empty), 32'(vecs[i].exp_tx_empty));
    end
    rx_trig = 5'd0;
    rx_space_man = 5'd16;
    rx_load_man = 1'b0;

    // Two back-to-back characters with the serializer always ready.
    tx_man_en = 1'b0;
    tx_push(8'h41);
    tx_push(8'h42);
    tx_ser.ready = 1'b1;
    tick(1);
    p0 = pull_cnt;
    x0 = xfer_cnt;
    tx_en = 1'b1;
    tick(1);
    check("tx1_pull_n1",  32'(tx_fifo_pull), 32'd1);
    check("tx1_valid_n1", 32'(tx_ser.valid), 32'd0);
    tick(1);
    check("tx1_pull_n2",  32'(tx_fifo_pull), 32'd0);
    check("tx1_valid_n2", 32'(tx_ser.valid), 32'd1);
    check("tx1_data_n2",  32'(tx_ser.data),  32'h41);
    tick(1);
    check("tx1_valid_n3", 32'(tx_ser.valid), 32'd0);
    check("tx1_pull_n3",  32'(tx_fifo_pull), 32'd0);
    tick(1);
    check("tx1_pull_n4",  32'(tx_fifo_pull), 32'd1);
    tick(1);
    check("tx1_valid_n5", 32'(tx_ser.valid), 32'd1);
    check("tx1_data_n5",  32'(tx_ser.data),  32'h42);
    tick(1);
    check("tx1_tx_empty_busy", 32'(irq_tx_empty), 32'd0);
    tick(1);
    check("tx1_tx_empty_done", 32'(irq_tx_empty), 32'd1);
    check("tx1_pulls",    32'(pull_cnt - p0), 32'd2);
    check("tx1_xfers",    32'(xfer_cnt - x0), 32'd2);
    check("tx1_last",     32'(last_xfer),     32'h42);

    // Serializer stalls for 10 cycles; the character must be held.
    tx_en = 1'b0;
    tx_ser.ready = 1'b0;
    tx_push(8'h55);
    p0 = pull_cnt;
    x0 = xfer_cnt;
    tx_en = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stall%0d_valid", i), 32'(tx_ser.valid), 32'd1);
      check($sformatf("stall%0d_data", i),  32'(tx_ser.data),  32'h55);
      tick(1);
    end
    check("stall_pulls", 32'(pull_cnt - p0), 32'd1);
    check("stall_xfers", 32'(xfer_cnt - x0), 32'd0);
    tx_ser.ready = 1'b1;
    tick(1);
    check("stall_xfer_once", 32'(xfer_cnt - x0), 32'd1);
    check("stall_xfer_data", 32'(last_xfer),     32'h55);
    check("stall_valid_low", 32'(tx_ser.valid),  32'd0);
    tx_en = 1'b0;
    tick(2);

    // Soft reset while a character is waiting in SEND.
    tx_ser.ready = 1'b0;
    tx_push(8'h77);
    tx_en = 1'b1;
    tick(2);
    check("srst_pre_valid", 32'(tx_ser.valid), 32'd1);
    p0 = pull_cnt;
    x0 = xfer_cnt;
    rst = 1'b1;
    tx_en = 1'b0;
    tick(1);
    rst = 1'b0;
    check("srst_valid",    32'(tx_ser.valid), 32'd0);
    check("srst_busy",     32'(tx_busy),      32'd0);
    check("srst_tx_empty", 32'(irq_tx_empty), 32'd1);
    check("srst_pull",     32'(tx_fifo_pull), 32'd0);
    check("srst_tx_data",  32'(tx_ser.data),  32'd0);
    tick(3);
    check("srst_no_pull",  32'(pull_cnt - p0), 32'd0);
    check("srst_no_xfer",  32'(xfer_cnt - x0), 32'd0);
    tx_ser.ready = 1'b1;

    // One free slot, two back-to-back characters: second one overruns.
    q0 = push_cnt;
    rx_en = 1'b1;
    rx_space_man = 5'd1;
    rx_valid = 1'b1;
    rx_data = 8'h10;
    tick(1);
    check("ovr_push1",    32'(rx_fifo_push), 32'd1);
    check("ovr_data1",    32'(rx_fifo_data), 32'h10);
    check("ovr_flag1",    32'(overrun),      32'd0);
    rx_data = 8'h11;
    tick(1);
    rx_valid = 1'b0;
    check("ovr_push2",    32'(rx_fifo_push), 32'd0);
    check("ovr_flag2",    32'(overrun),      32'd1);
    check("ovr_data_kept",32'(rx_fifo_data), 32'h10);
    tick(2);
    check("ovr_sticky",   32'(overrun),      32'd1);
    check("ovr_pushes",   32'(push_cnt - q0), 32'd1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("ovr_cleared",  32'(overrun),      32'd0);
    // Set and clear in the same cycle: set wins.
    rx_space_man = 5'd0;
    rx_valid = 1'b1;
    rx_data = 8'h12;
    overrun_clr = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    overrun_clr = 1'b0;
    check("ovr_set_wins", 32'(overrun),      32'd1);
    check("ovr_full_nopush", 32'(rx_fifo_push), 32'd0);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    // Receiver disabled: character dropped, no overrun even when full.
    rx_en = 1'b0;
    rx_valid = 1'b1;
    rx_data = 8'h13;
    tick(1);
    rx_valid = 1'b0;
    check("rxdis_push",    32'(rx_fifo_push), 32'd0);
    check("rxdis_overrun", 32'(overrun),      32'd0);

    // Fill an empty RX FIFO to the trigger level of 4.
    rx_base = rx_cnt;
    rx_model_en = 1'b1;
    rx_trig = 5'd4;
    rx_en = 1'b1;
    q0 = push_cnt;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data = 8'(8'h20 + i);
      tick(1);
    end
    rx_valid = 1'b0;
    tick(1);
    check("trig_fill4",  32'(rx_cnt - rx_base), 32'd4);
    check("trig_irq_lo", 32'(irq_rx),           32'd0);
    tick(1);
    check("trig_irq_hi", 32'(irq_rx),           32'd1);
    check("trig_pushes", 32'(push_cnt - q0),    32'd4);
    check("trig_last",   32'(last_push),        32'h23);
    rx_trig = 5'd0;
    tick(1);
    check("trig_zero_off", 32'(irq_rx),         32'd0);

    // Character timeout: one byte held below the trigger, receiver idle.
    rx_model_en = 1'b0;
    rx_space_man = 5'd15;
    rx_load_man = 1'b1;
    rx_trig = 5'd4;
    rx_en = 1'b0;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(10);
    check("to_early", 32'(irq_rx_timeout), 32'd0);
    tick(10);
    check("to_fired", 32'(irq_rx_timeout), 32'(TO_EN));
    tick(3);
    check("to_held",  32'(irq_rx_timeout), 32'(TO_EN));
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    check("to_cleared", 32'(irq_rx_timeout), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
